// File: rtl/reg_file_be_dbuf.sv
// rtl/reg_file_be_dbuf.sv - double-buffered byte-lane register file with valid/ready output bank
module reg_file_be_dbuf #(
  parameter int BYTE_W     = 8,
  parameter int DEPTH      = 13,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      wr_mode,
  input  logic                      wren,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [BYTE_W-1:0]         data,
  output logic                      wr_ready,
  output logic [ADDR_WIDTH:0]       fill_cnt,
  output logic                      q_valid,
  input  logic                      q_ready,
  output logic [DEPTH*BYTE_W-1:0]   q,
  output logic                      ovf,
  output logic                      err
);

  typedef enum logic [0:0] {FILL, XFER} state_e;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  state_e                  state_q;
  logic [BYTE_W-1:0]       bank_q [DEPTH];
  logic [BYTE_W-1:0]       out_q  [DEPTH];
  logic [DEPTH-1:0]        mask_q;
  logic [DEPTH-1:0]        mask_d;
  logic [ADDR_WIDTH:0]     ptr_q;
  logic                    q_valid_q;
  logic                    ovf_q;
  logic                    err_q;

  logic [ADDR_WIDTH-1:0]   lane_sel;
  logic                    lane_in_range;
  logic                    wr_fire;
  logic                    wr_ok;
  logic                    bad_addr;
  logic                    xfer_go;

  // Decode the current write: target lane, legality, and the mask it would produce
  always_comb begin
    wr_fire       = wren && (state_q == FILL);
    lane_sel      = wr_mode ? ptr_q[ADDR_WIDTH-1:0] : wr_addr;
    lane_in_range = wr_mode ? (ptr_q < DEPTH_W) : ({1'b0, wr_addr} < DEPTH_W);
    wr_ok         = wr_fire && lane_in_range;
    bad_addr      = wr_fire && !wr_mode && !lane_in_range;
    xfer_go       = (state_q == XFER) && (!q_valid_q || q_ready);
    mask_d        = mask_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (lane_sel == i[ADDR_WIDTH-1:0])) begin
        mask_d[i] = 1'b1;
      end
    end
  end

  // Lane-written count is simply the population of the mask
  always_comb begin
    fill_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fill_cnt = fill_cnt + {{ADDR_WIDTH{1'b0}}, mask_q[i]};
    end
  end

  // Fill/transfer FSM together with both banks and the sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      mask_q    <= '0;
      ptr_q     <= '0;
      q_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else if (clr) begin
      // Abort restarts bookkeeping only; lane data in both banks is kept
      state_q   <= FILL;
      mask_q    <= '0;
      ptr_q     <= '0;
      q_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (wren && (state_q != FILL)) begin
        ovf_q <= 1'b1;
      end
      if (bad_addr) begin
        err_q <= 1'b1;
      end
      if (wr_ok) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (lane_sel == i[ADDR_WIDTH-1:0]) begin
            bank_q[i] <= data;
          end
        end
        mask_q <= mask_d;
        if (wr_mode) begin
          ptr_q <= ptr_q + (ADDR_WIDTH+1)'(1);
        end
        if (&mask_d) begin
          state_q <= XFER;
        end
      end
      if (q_valid_q && q_ready) begin
        q_valid_q <= 1'b0;
      end
      // A transfer loading the output bank wins over the consume that frees it
      if (xfer_go) begin
        for (int i = 0; i < DEPTH; i++) begin
          out_q[i] <= bank_q[i];
        end
        q_valid_q <= 1'b1;
        mask_q    <= '0;
        ptr_q     <= '0;
        state_q   <= FILL;
      end
    end
  end

  // Flatten the output bank onto q, lane i at byte position i
  always_comb begin
    q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q[i*BYTE_W +: BYTE_W] = out_q[i];
    end
  end

  assign wr_ready = (state_q == FILL);
  assign q_valid  = q_valid_q;
  assign ovf      = ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_reg_file_be_dbuf.sv
// tb/tb_reg_file_be_dbuf.sv - directed self-checking bench for reg_file_be_dbuf
module tb_reg_file_be_dbuf;

  localparam int BYTE_W     = 8;
  localparam int DEPTH      = 13;
  localparam int ADDR_WIDTH = 5;

  logic                    clk;
  logic                    rst_n;
  logic                    clr;
  logic                    wr_mode;
  logic                    wren;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [BYTE_W-1:0]       data;
  logic                    wr_ready;
  logic [ADDR_WIDTH:0]     fill_cnt;
  logic                    q_valid;
  logic                    q_ready;
  logic [DEPTH*BYTE_W-1:0] q;
  logic                    ovf;
  logic                    err;

  int checks;
  int errors;

  logic [DEPTH*BYTE_W-1:0] exp_w1;
  logic [DEPTH*BYTE_W-1:0] exp_w2;
  logic [DEPTH*BYTE_W-1:0] exp_w3;
  logic [DEPTH*BYTE_W-1:0] exp_w4;

  reg_file_be_dbuf #(
    .BYTE_W     (BYTE_W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr_mode  (wr_mode),
    .wren     (wren),
    .wr_addr  (wr_addr),
    .data     (data),
    .wr_ready (wr_ready),
    .fill_cnt (fill_cnt),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .q        (q),
    .ovf      (ovf),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_seq(input logic [7:0] d);
    wren = 1'b1; wr_mode = 1'b1; data = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic write_addr(input logic [4:0] a, input logic [7:0] d);
    wren = 1'b1; wr_mode = 1'b0; wr_addr = a; data = d;
    tick();
    wren = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; clr = 1'b0; wr_mode = 1'b0; wren = 1'b0;
    wr_addr = '0; data = '0; q_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_w1[i*8 +: 8] = 8'(i + 1);
      exp_w2[i*8 +: 8] = (i == 5) ? 8'h55 : 8'(8'h20 + i);
      exp_w3[i*8 +: 8] = 8'(8'h40 + i);
      exp_w4[i*8 +: 8] = 8'(8'h80 + i);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();

    check("rst_wr_ready", wr_ready, 1);
    check("rst_fill_cnt", fill_cnt, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_q", q, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);

    // Sequential fill with the consumer ready
    q_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      write_seq(8'(i + 1));
      if (i == 0) check("seq_cnt_first", fill_cnt, 1);
    end
    check("seq_full_cnt", fill_cnt, 13);
    check("seq_full_wr_ready", wr_ready, 0);
    check("seq_full_q_valid", q_valid, 0);
    tick();
    check("seq_xfer_q_valid", q_valid, 1);
    check("seq_xfer_wr_ready", wr_ready, 1);
    check("seq_xfer_cnt", fill_cnt, 0);
    check("seq_xfer_q", q, exp_w1);
    tick();
    check("seq_consumed", q_valid, 0);

    // Addressed fill in reverse order, lane 5 rewritten
    q_ready = 1'b0;
    for (int a = 12; a >= 6; a--) write_addr(5'(a), 8'(8'h20 + a));
    write_addr(5'd5, 8'hAA);
    write_addr(5'd5, 8'h55);
    check("addr_rewrite_cnt", fill_cnt, 8);
    for (int a = 4; a >= 1; a--) write_addr(5'(a), 8'(8'h20 + a));
    check("addr_12_cnt", fill_cnt, 12);
    check("addr_12_wr_ready", wr_ready, 1);
    write_addr(5'd0, 8'h20);
    check("addr_full_cnt", fill_cnt, 13);
    check("addr_full_wr_ready", wr_ready, 0);
    tick();
    check("addr_q_valid", q_valid, 1);
    check("addr_q", q, exp_w2);

    // Second word completes while the first is still held
    for (int i = 0; i < DEPTH; i++) write_seq(8'(8'h40 + i));
    tick();
    check("hold_wr_ready", wr_ready, 0);
    check("hold_q_valid", q_valid, 1);
    check("hold_q_stable", q, exp_w2);
    write_seq(8'hFF);
    check("hold_ovf", ovf, 1);
    check("hold_q_after_ovf", q, exp_w2);
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    check("swap_q_valid", q_valid, 1);
    check("swap_q", q, exp_w3);
    check("swap_wr_ready", wr_ready, 1);
    tick();
    check("swap_q_valid_held", q_valid, 1);

    // Out-of-range addressed writes
    write_addr(5'd0, 8'h11);
    check("err_pre_cnt", fill_cnt, 1);
    check("err_pre", err, 0);
    write_addr(5'd13, 8'hEE);
    check("err_13", err, 1);
    check("err_13_cnt", fill_cnt, 1);
    write_addr(5'd31, 8'hEF);
    check("err_31_cnt", fill_cnt, 1);

    // Abort after seven writes, then a fresh word
    for (int a = 1; a <= 6; a++) write_addr(5'(a), 8'h33);
    check("clr_pre_cnt", fill_cnt, 7);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_cnt", fill_cnt, 0);
    check("clr_q_valid", q_valid, 0);
    check("clr_ovf", ovf, 0);
    check("clr_err", err, 0);
    check("clr_wr_ready", wr_ready, 1);
    q_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_seq(8'(8'h80 + i));
    tick();
    check("fresh_q_valid", q_valid, 1);
    check("fresh_q", q, exp_w4);
    check("fresh_err", err, 0);

    // Reset while holding in XFER
    q_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) write_seq(8'(8'hC0 + i));
    check("prerst_wr_ready", wr_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_q", q, 0);
    check("rst_mid_q_valid", q_valid, 0);
    check("rst_mid_wr_ready", wr_ready, 1);
    check("rst_mid_cnt", fill_cnt, 0);
    tick();
    rst_n = 1'b1;
    q_ready = 1'b1;
    tick(); tick();
    check("post_rst_q_valid", q_valid, 0);
    write_seq(8'h01);
    check("post_rst_cnt", fill_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
